// File: rtl/axi_pkg.sv
// Shared AXI types and helpers for the LLC burst master.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } axi_mst_state_t;

  // Number of address bits covered by one cache line (burst_len beats of data_w bits).
  function automatic int line_off_w(input int data_w, input int burst_len);
    return $clog2(burst_len * data_w / 8);
  endfunction

endpackage

// File: rtl/axi_beat_shifter.sv
// Line buffer plus beat counter. Serialises a loaded line beat by beat (write)
// or assembles incoming beats into the line (read); the counter saturates at
// BURST_LEN so surplus beats are ignored.
module axi_beat_shifter #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [BURST_LEN*DATA_W-1:0] load_line,
  input  logic                        advance,
  input  logic                        capture,
  input  logic [DATA_W-1:0]           beat_in,
  output logic [BURST_LEN*DATA_W-1:0] line_nxt,
  output logic [DATA_W-1:0]           beat,
  output logic                        last,
  output logic                        full
);

  localparam int LINE_W = BURST_LEN * DATA_W;
  localparam int CNT_W  = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BURST_LEN);

  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  idx;

  assign last = (cnt_q == LAST_IDX);
  assign full = (cnt_q == FULL_CNT);

  // Current beat out, and the line as it will look once the incoming beat lands.
  always_comb begin
    idx      = full ? '0 : cnt_q;
    beat     = line_q[int'(idx)*DATA_W +: DATA_W];
    line_nxt = line_q;
    if (capture && !full) line_nxt[int'(idx)*DATA_W +: DATA_W] = beat_in;
  end

  // Load a fresh line or step one beat per handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      line_q <= load_line;
      cnt_q  <= '0;
    end else if (advance) begin
      line_q <= line_nxt;
      if (!full) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 burst master: turns LLC cache-line read/write requests into one
// BURST_LEN-beat INCR burst each, one transaction outstanding at a time.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [BURST_LEN*DATA_W-1:0] req_wdata,
  output logic                        resp_valid,
  output logic                        resp_write,
  output logic                        resp_err,
  output logic [BURST_LEN*DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0]           AWADDR,
  output logic [7:0]                  AWLEN,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [DATA_W-1:0]           WDATA,
  output logic                        WLAST,
  output logic                        WVALID,
  input  logic                        WREADY,
  input  logic [1:0]                  BRESP,
  input  logic                        BVALID,
  output logic                        BREADY,
  output logic [ADDR_W-1:0]           ARADDR,
  output logic [7:0]                  ARLEN,
  output logic                        ARVALID,
  input  logic                        ARREADY,
  input  logic [DATA_W-1:0]           RDATA,
  input  logic [1:0]                  RRESP,
  input  logic                        RLAST,
  input  logic                        RVALID,
  output logic                        RREADY
);

  localparam int LINE_W = BURST_LEN * DATA_W;
  localparam int OFF_W  = line_off_w(DATA_W, BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [7:0]        AX_LEN    = 8'(BURST_LEN - 1);

  axi_mst_state_t    state;
  logic              err;
  logic              aw_done;
  logic              accept;
  logic              aw_hs, w_hs, r_hs;
  logic              w_full, rd_last;
  logic              bresp_bad, beat_err;
  logic [ADDR_W-1:0] addr_aligned;
  logic [LINE_W-1:0] rd_line_nxt;
  logic [LINE_W-1:0] wr_line_unused;
  logic [DATA_W-1:0] rd_beat_unused;
  logic              rd_full_unused;

  assign AWLEN        = AX_LEN;
  assign ARLEN        = AX_LEN;
  assign accept       = req_valid && req_ready;
  assign aw_hs        = AWVALID && AWREADY;
  assign w_hs         = WVALID && WREADY;
  assign r_hs         = RVALID && RREADY;
  assign addr_aligned = req_addr & ADDR_MASK;
  assign bresp_bad    = (axi_resp_t'(BRESP) != OKAY);
  // A beat is bad on a non-OKAY response or when RLAST disagrees with the beat position.
  assign beat_err     = (axi_resp_t'(RRESP) != OKAY) || (RLAST != rd_last);

  axi_beat_shifter #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) u_wr_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_line (req_wdata),
    .advance   (w_hs),
    .capture   (1'b0),
    .beat_in   ({DATA_W{1'b0}}),
    .line_nxt  (wr_line_unused),
    .beat      (WDATA),
    .last      (WLAST),
    .full      (w_full)
  );

  axi_beat_shifter #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) u_rd_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_line ({LINE_W{1'b0}}),
    .advance   (r_hs),
    .capture   (1'b1),
    .beat_in   (RDATA),
    .line_nxt  (rd_line_nxt),
    .beat      (rd_beat_unused),
    .last      (rd_last),
    .full      (rd_full_unused)
  );

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      AWVALID    <= 1'b0;
      WVALID     <= 1'b0;
      BREADY     <= 1'b0;
      ARVALID    <= 1'b0;
      RREADY     <= 1'b0;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      AWADDR     <= '0;
      ARADDR     <= '0;
      err        <= 1'b0;
      aw_done    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            err       <= 1'b0;
            aw_done   <= 1'b0;
            if (req_write) begin
              AWADDR  <= addr_aligned;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= ST_WR_BURST;
            end else begin
              ARADDR  <= addr_aligned;
              ARVALID <= 1'b1;
              state   <= ST_RD_ADDR;
            end
          end
        end
        ST_WR_BURST: begin
          if (aw_hs) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs && WLAST) WVALID <= 1'b0;
          // AW and the final W beat may finish in either order or together.
          if ((aw_done || aw_hs) && (w_full || (w_hs && WLAST))) begin
            BREADY <= 1'b1;
            state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (BVALID) begin
            BREADY     <= 1'b0;
            err        <= err || bresp_bad;
            resp_valid <= 1'b1;
            resp_write <= 1'b1;
            resp_err   <= err || bresp_bad;
            state      <= ST_DONE;
          end
        end
        ST_RD_ADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          // RREADY stays high past a missing RLAST so the slave can drain.
          if (r_hs) begin
            err <= err || beat_err;
            if (RLAST) begin
              RREADY     <= 1'b0;
              resp_valid <= 1'b1;
              resp_write <= 1'b0;
              resp_err   <= err || beat_err;
              resp_rdata <= rd_line_nxt;
              state      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboarded bench for axi_burst_master (BURST_LEN=4, DATA_W=64).
module tb_axi_burst_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int BL     = 4;
  localparam int LW     = BL * DATA_W;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LW-1:0] req_wdata;
  logic resp_valid, resp_write, resp_err;
  logic [LW-1:0] resp_rdata;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DATA_W-1:0] WDATA, RDATA;
  logic [1:0] BRESP, RRESP;

  axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_write(resp_write), .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic          err;
    logic [LW-1:0] rdata;
    logic [LW-1:0] rmask;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] w_data[$];
  logic              w_last[$];
  int                w_stamp[$];
  logic [ADDR_W-1:0] aw_addr[$];
  int                aw_stamp[$];
  logic [ADDR_W-1:0] ar_addr[$];
  logic [7:0]        ar_len[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int resp_cnt = 0;
  logic prev_resp = 1'b0;
  logic aw_stall = 1'b0, w_stall = 1'b0;
  logic [ADDR_W-1:0] aw_prev;
  logic [DATA_W-1:0] w_prev;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] wbeat(input logic [DATA_W-1:0] base, input int i);
    return base + DATA_W'(i);
  endfunction

  function automatic logic [DATA_W-1:0] rbeat(input int i);
    return 64'h1111_1111_1111_1111 * DATA_W'(i + 1);
  endfunction

  function automatic logic [LW-1:0] wline(input logic [DATA_W-1:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < BL; i++) l[i*DATA_W +: DATA_W] = wbeat(base, i);
    return l;
  endfunction

  function automatic logic [LW-1:0] rline(input int nbeats);
    logic [LW-1:0] l = '0;
    for (int i = 0; i < nbeats && i < BL; i++) l[i*DATA_W +: DATA_W] = rbeat(i);
    return l;
  endfunction

  function automatic logic [LW-1:0] beat_mask(input int nbeats);
    logic [LW-1:0] m = '0;
    for (int i = 0; i < nbeats; i++) m[i*DATA_W +: DATA_W] = '1;
    return m;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Negedge monitor: handshake capture, AXI stability, scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      aw_stall  <= 1'b0;
      w_stall   <= 1'b0;
      prev_resp <= 1'b0;
    end else begin
      if (aw_stall) begin
        check("aw_hold_valid", AWVALID, 1'b1);
        check("aw_hold_addr", AWADDR, aw_prev);
      end
      if (w_stall) begin
        check("w_hold_valid", WVALID, 1'b1);
        check("w_hold_data", WDATA, w_prev);
      end
      aw_stall <= AWVALID && !AWREADY;
      w_stall  <= WVALID && !WREADY;
      aw_prev  <= AWADDR;
      w_prev   <= WDATA;
      if (AWVALID && AWREADY) begin
        aw_addr.push_back(AWADDR);
        aw_stamp.push_back(cyc);
      end
      if (WVALID && WREADY) begin
        w_data.push_back(WDATA);
        w_last.push_back(WLAST);
        w_stamp.push_back(cyc);
      end
      if (ARVALID && ARREADY) begin
        ar_addr.push_back(ARADDR);
        ar_len.push_back(ARLEN);
      end
      prev_resp <= resp_valid;
      if (resp_valid) begin
        exp_t e;
        check("resp_pulse_width", prev_resp, 1'b0);
        if (sb.size() == 0) begin
          check("resp_unexpected", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("resp_write", resp_write, e.wr);
          check("resp_err", resp_err, e.err);
          if (!e.wr) check("resp_rdata", resp_rdata & e.rmask, e.rdata & e.rmask);
        end
        resp_cnt <= resp_cnt + 1;
      end
    end
  end

  task automatic clear_mon();
    w_data.delete(); w_last.delete(); w_stamp.delete();
    aw_addr.delete(); aw_stamp.delete(); ar_addr.delete(); ar_len.delete();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [LW-1:0] wd,
                          input exp_t e);
    int n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    check("req_ready_wait", req_ready, 1'b1);
    sb.push_back(e);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_b(input logic [1:0] resp, input int delay);
    int n = 0;
    while (!BREADY && n < 50) begin step(); n++; end
    check("bready_wait", BREADY, 1'b1);
    repeat (delay) step();
    BVALID = 1'b1; BRESP = resp;
    step();
    BVALID = 1'b0; BRESP = 2'b00;
  endtask

  task automatic do_r(input int nbeats, input int last_idx, input int err_idx, input logic [1:0] ecode);
    int n = 0;
    while (!RREADY && n < 50) begin step(); n++; end
    for (int i = 0; i < nbeats; i++) begin
      check($sformatf("rready_beat%0d", i), RREADY, 1'b1);
      RVALID = 1'b1; RDATA = rbeat(i);
      RRESP = (i == err_idx) ? ecode : 2'b00;
      RLAST = (i == last_idx);
      step();
    end
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_cnt < target && n < 200) begin step(); n++; end
    check("resp_count", resp_cnt, target);
  endtask

  initial begin
    int base_cnt;
    logic [LW-1:0] held;
    rst = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = '0; RRESP = 0; RLAST = 0;
    repeat (3) step();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, resp_valid}, 6'b0);
    check("rst_resp_flags", {resp_err, resp_write}, 2'b0);
    check("rst_addr", {AWADDR, ARADDR}, 64'h0);
    check("rst_wdata", WDATA, 64'h0);
    check("rst_rdata", resp_rdata, '0);
    rst = 1'b0;
    step();

    // Write, always-ready slave
    clear_mon();
    AWREADY = 1; WREADY = 1;
    send_req(1'b1, 32'h1000_0013, wline(64'hA0A0_A0A0_A0A0_A0A0), '{1'b1, 1'b0, '0, '0});
    check("wr1_awvalid", AWVALID, 1'b1);
    check("wr1_awaddr", AWADDR, 32'h1000_0000);
    check("wr1_awlen", AWLEN, 8'd3);
    check("wr1_wvalid", WVALID, 1'b1);
    check("wr1_wdata0", WDATA, 64'hA0A0_A0A0_A0A0_A0A0);
    check("wr1_wlast0", WLAST, 1'b0);
    do_b(2'b00, 0);
    wait_resp(1);
    check("wr1_nbeats", w_data.size(), BL);
    check("wr1_naw", aw_addr.size(), 1);
    for (int i = 0; i < BL && i < w_data.size(); i++) begin
      check($sformatf("wr1_beat%0d", i), w_data[i], wbeat(64'hA0A0_A0A0_A0A0_A0A0, i));
      check($sformatf("wr1_last%0d", i), w_last[i], (i == BL - 1));
      check($sformatf("wr1_stamp%0d", i), w_stamp[i], w_stamp[0] + i);
    end
    AWREADY = 0; WREADY = 0;

    // Write, AW held off 7 cycles, WREADY toggling
    clear_mon();
    send_req(1'b1, 32'h2000_0040, wline(64'hB0B0_B0B0_B0B0_B0B0), '{1'b1, 1'b0, '0, '0});
    for (int k = 0; k < 8; k++) begin
      WREADY = (k % 2 == 0) && (k < 7);
      AWREADY = (k == 7);
      step();
    end
    AWREADY = 0; WREADY = 0;
    base_cnt = resp_cnt;
    repeat (2) step();
    check("wr2_no_early_resp", resp_cnt, base_cnt);
    do_b(2'b00, 3);
    wait_resp(2);
    check("wr2_nbeats", w_data.size(), BL);
    check("wr2_naw", aw_addr.size(), 1);
    if (aw_addr.size() == 1) check("wr2_awaddr", aw_addr[0], 32'h2000_0040);
    for (int i = 0; i < BL && i < w_data.size(); i++) begin
      check($sformatf("wr2_beat%0d", i), w_data[i], wbeat(64'hB0B0_B0B0_B0B0_B0B0, i));
      check($sformatf("wr2_last%0d", i), w_last[i], (i == BL - 1));
      if (aw_stamp.size() == 1) check($sformatf("wr2_before_aw%0d", i), w_stamp[i] < aw_stamp[0], 1'b1);
    end

    // Clean read
    clear_mon();
    ARREADY = 1;
    send_req(1'b0, 32'h3000_0025, '0, '{1'b0, 1'b0, rline(4), beat_mask(4)});
    do_r(4, 3, -1, 2'b00);
    wait_resp(3);
    check("rd1_nar", ar_addr.size(), 1);
    if (ar_addr.size() == 1) begin
      check("rd1_araddr", ar_addr[0], 32'h3000_0020);
      check("rd1_arlen", ar_len[0], 8'd3);
    end

    // Read with SLVERR on beat 2
    send_req(1'b0, 32'h3000_0100, '0, '{1'b0, 1'b1, rline(4), beat_mask(4)});
    do_r(4, 3, 1, 2'b10);
    wait_resp(4);
    held = resp_rdata;

    // Write with DECERR; AW and last W beat in the same cycle
    AWREADY = 0; WREADY = 1;
    send_req(1'b1, 32'h4000_0000, wline(64'hC0C0_C0C0_C0C0_C0C0), '{1'b1, 1'b1, '0, '0});
    repeat (3) step();
    AWREADY = 1;
    step();
    AWREADY = 0; WREADY = 0;
    do_b(2'b11, 1);
    wait_resp(5);
    check("rdata_held_over_write", resp_rdata, held);

    // OKAY read after errors
    send_req(1'b0, 32'h3000_0200, '0, '{1'b0, 1'b0, rline(4), beat_mask(4)});
    do_r(4, 3, -1, 2'b00);
    wait_resp(6);

    // RLAST early on beat 2
    send_req(1'b0, 32'h3000_0300, '0, '{1'b0, 1'b1, rline(2), beat_mask(2)});
    do_r(2, 1, -1, 2'b00);
    wait_resp(7);
    step();
    check("early_rlast_idle", req_ready, 1'b1);

    // RLAST missing on beat 4, arrives on beat 6
    send_req(1'b0, 32'h3000_0400, '0, '{1'b0, 1'b1, rline(4), beat_mask(4)});
    do_r(6, 5, -1, 2'b00);
    wait_resp(8);

    // Reset mid-write after two W beats
    AWREADY = 0; WREADY = 1;
    send_req(1'b1, 32'h5000_0000, wline(64'hD0D0_D0D0_D0D0_D0D0), '{1'b1, 1'b0, '0, '0});
    void'(sb.pop_back());
    base_cnt = resp_cnt;
    repeat (2) step();
    rst = 1'b1;
    step();
    check("rst_mid_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, resp_valid}, 6'b0);
    check("rst_mid_req_ready", req_ready, 1'b1);
    step();
    rst = 1'b0; WREADY = 0;
    repeat (3) step();
    check("rst_mid_no_resp", resp_cnt, base_cnt);
    send_req(1'b0, 32'h3000_0500, '0, '{1'b0, 1'b0, rline(4), beat_mask(4)});
    do_r(4, 3, -1, 2'b00);
    wait_resp(base_cnt + 1);
    repeat (3) step();
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
